// File: rtl/fib_datapath_pkg.sv
// Shared opcode encodings and flag bit positions for the fibonacci datapath and its controller.
package fib_datapath_pkg;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_ADDU  = 8'h06,
    OP_SUB   = 8'h09,
    OP_CMP   = 8'h0B,
    OP_ADDUI = 8'h60
  } opcode_e;

  localparam int FL_L = 4;
  localparam int FL_Z = 3;
  localparam int FL_N = 2;
  localparam int FL_F = 1;
  localparam int FL_C = 0;

  localparam int FLAGS_W = 5;

endpackage

// File: rtl/fib_datapath_alu_core.sv
// Combinational ALU: computes the result and the flags each opcode defines,
// with a per-bit update mask so the caller can hold every flag the op leaves alone.
module alu_core
  import fib_datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [7:0]         opcode,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] flags_next,
  output logic [FLAGS_W-1:0] flags_upd,
  output logic               wr_ok,
  output logic               legal
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result     = '0;
    flags_next = '0;
    flags_upd  = '0;
    wr_ok      = 1'b0;
    legal      = 1'b1;
    case (opcode)
      OP_ADDU, OP_ADDUI: begin
        result           = sum[DATA_W-1:0];
        wr_ok            = 1'b1;
        flags_next[FL_C] = sum[DATA_W];
        flags_next[FL_F] = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        flags_upd[FL_C]  = 1'b1;
        flags_upd[FL_F]  = 1'b1;
      end
      OP_SUB: begin
        result           = diff[DATA_W-1:0];
        wr_ok            = 1'b1;
        flags_next[FL_C] = diff[DATA_W];
        flags_next[FL_F] = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        flags_upd[FL_C]  = 1'b1;
        flags_upd[FL_F]  = 1'b1;
      end
      OP_CMP: begin
        flags_next[FL_L] = (a < b);
        flags_next[FL_Z] = (a == b);
        flags_next[FL_N] = ($signed(a) < $signed(b));
        flags_upd[FL_L]  = 1'b1;
        flags_upd[FL_Z]  = 1'b1;
        flags_upd[FL_N]  = 1'b1;
      end
      OP_NOP: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fib_datapath.sv
// Execution datapath: register file, flag register and display register driven
// by the controller's per-cycle control word; one ALU op per clock.
module fib_datapath
  import fib_datapath_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int OUT_REG  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REGS-1:0]         wEnable,
  input  logic [DATA_W-1:0]           Imm_in,
  input  logic [7:0]                  opcode,
  input  logic [$clog2(NUM_REGS)-1:0] Rdest_sel,
  input  logic [$clog2(NUM_REGS)-1:0] Rsrc_sel,
  input  logic                        Imm_sel,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [FLAGS_W-1:0]          Flags_out,
  output logic [DATA_W-1:0]           out_data,
  output logic [DATA_W-1:0]           dbg_data,
  output logic                        illegal_op
);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [FLAGS_W-1:0] flags_q;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  alu_result;
  logic [FLAGS_W-1:0] alu_flags;
  logic [FLAGS_W-1:0] alu_upd;
  logic               alu_wr_ok;
  logic               alu_legal;

  assign op_a     = regs[Rdest_sel];
  assign op_b     = Imm_sel ? regs[Rsrc_sel] : Imm_in;
  assign dbg_data = regs[dbg_sel];

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a          (op_a),
    .b          (op_b),
    .opcode     (opcode),
    .result     (alu_result),
    .flags_next (alu_flags),
    .flags_upd  (alu_upd),
    .wr_ok      (alu_wr_ok),
    .legal      (alu_legal)
  );

  // out_data tracks the value R[OUT_REG] takes at this edge, so it never lags the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      flags_q    <= '0;
      out_data   <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (alu_wr_ok) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wEnable[k]) regs[k] <= alu_result;
        end
      end
      flags_q  <= (flags_q & ~alu_upd) | (alu_flags & alu_upd);
      out_data <= (alu_wr_ok && wEnable[OUT_REG]) ? alu_result : regs[OUT_REG];
      if (!alu_legal) illegal_op <= 1'b1;
    end
  end

  // CMP results are forwarded in the same cycle so the controller can branch without a wait state.
  always_comb begin
    Flags_out = flags_q;
    if (opcode == OP_CMP) begin
      Flags_out[FL_L] = alu_flags[FL_L];
      Flags_out[FL_Z] = alu_flags[FL_Z];
      Flags_out[FL_N] = alu_flags[FL_N];
    end
  end

endmodule

// File: tb/tb_fib_datapath.sv
// Self-checking bench for fib_datapath: vector table with a register model and an out_data scoreboard.
module tb_fib_datapath;
  import fib_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wEnable;
  logic [15:0] Imm_in;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_sel;
  logic [3:0]  Rsrc_sel;
  logic        Imm_sel;
  logic [3:0]  dbg_sel;
  logic [4:0]  Flags_out;
  logic [15:0] out_data;
  logic [15:0] dbg_data;
  logic        illegal_op;

  fib_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .wEnable    (wEnable),
    .Imm_in     (Imm_in),
    .opcode     (opcode),
    .Rdest_sel  (Rdest_sel),
    .Rsrc_sel   (Rsrc_sel),
    .Imm_sel    (Imm_sel),
    .dbg_sel    (dbg_sel),
    .Flags_out  (Flags_out),
    .out_data   (out_data),
    .dbg_data   (dbg_data),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] we;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        isel;
    logic [3:0]  dsel;
    logic        chk;
    logic [4:0]  exp_live;
    logic [4:0]  exp_flags;
    logic [15:0] exp_dbg;
    logic        exp_ill;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mdl_regs [16];
  logic [15:0] exp_q [$];
  vec_t        vecs [18];

  function automatic vec_t mk(logic [7:0] op, logic [15:0] we, logic [15:0] imm,
                              logic [3:0] rd, logic [3:0] rs, logic isel, logic [3:0] dsel,
                              logic chk, logic [4:0] live, logic [4:0] flg,
                              logic [15:0] dbg, logic ill);
    vec_t v;
    v.op = op; v.we = we; v.imm = imm; v.rd = rd; v.rs = rs; v.isel = isel;
    v.dsel = dsel; v.chk = chk; v.exp_live = live; v.exp_flags = flg;
    v.exp_dbg = dbg; v.exp_ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drives one op, checks same-cycle outputs, advances the model and queues the expected out_data.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    @(negedge clk);
    opcode = v.op; wEnable = v.we; Imm_in = v.imm; Rdest_sel = v.rd;
    Rsrc_sel = v.rs; Imm_sel = v.isel; dbg_sel = v.dsel;
    #1;
    check({tag, " dbg_old"}, dbg_data, mdl_regs[v.dsel]);
    if (v.chk) check({tag, " flags_live"}, Flags_out, v.exp_live);
    a = mdl_regs[v.rd];
    b = v.isel ? mdl_regs[v.rs] : v.imm;
    r = 16'h0;
    if (v.op == OP_ADDU || v.op == OP_ADDUI) r = a + b;
    if (v.op == OP_SUB) r = a - b;
    if (v.op == OP_ADDU || v.op == OP_ADDUI || v.op == OP_SUB) begin
      for (int k = 0; k < 16; k++) if (v.we[k]) mdl_regs[k] = r;
    end
    exp_q.push_back(mdl_regs[5]);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [15:0] e;
    @(posedge clk);
    #1;
    opcode = OP_NOP;
    #1;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " out_data"}, out_data, e);
    end
    if (v.chk) begin
      check({tag, " flags_reg"}, Flags_out, v.exp_flags);
      check({tag, " dbg_new"}, dbg_data, v.exp_dbg);
      check({tag, " illegal_op"}, illegal_op, v.exp_ill);
    end
  endtask

  task automatic checkResetState(input string tag);
    opcode = OP_NOP;
    for (int k = 0; k < 16; k++) begin
      dbg_sel = k[3:0];
      #1;
      check($sformatf("%s R%0d", tag, k), dbg_data, 32'h0);
    end
    check({tag, " flags"}, Flags_out, 32'h0);
    check({tag, " out_data"}, out_data, 32'h0);
    check({tag, " illegal_op"}, illegal_op, 32'h0);
  endtask

  task automatic clearModel();
    for (int k = 0; k < 16; k++) mdl_regs[k] = 16'h0;
    exp_q.delete();
  endtask

  initial begin
    vec_t fv;
    //            op     we       imm      rd rs is ds chk live      flags     dbg      ill
    vecs[0]  = mk(8'h60, 16'h0002, 16'h0001, 1, 0, 0, 1, 1, 5'b00000, 5'b00000, 16'h0001, 0);
    vecs[1]  = mk(8'h06, 16'h0004, 16'h0000, 1, 1, 1, 2, 1, 5'b00000, 5'b00000, 16'h0002, 0);
    vecs[2]  = mk(8'h60, 16'h0008, 16'h0003, 0, 0, 0, 3, 1, 5'b00000, 5'b00000, 16'h0003, 0);
    vecs[3]  = mk(8'h60, 16'h0010, 16'h000A, 0, 0, 0, 4, 1, 5'b00000, 5'b00000, 16'h000A, 0);
    vecs[4]  = mk(8'h0B, 16'hFFFF, 16'h0000, 3, 4, 1, 0, 1, 5'b10100, 5'b10100, 16'h0000, 0);
    vecs[5]  = mk(8'h0B, 16'h0000, 16'h0000, 4, 3, 1, 4, 1, 5'b00000, 5'b00000, 16'h000A, 0);
    vecs[6]  = mk(8'h0B, 16'h0000, 16'h0000, 3, 3, 1, 3, 1, 5'b01000, 5'b01000, 16'h0003, 0);
    vecs[7]  = mk(8'h60, 16'h0022, 16'hFFFF, 0, 0, 0, 5, 1, 5'b01000, 5'b01000, 16'hFFFF, 0);
    vecs[8]  = mk(8'h60, 16'h0022, 16'h0001, 1, 0, 0, 5, 1, 5'b01000, 5'b01001, 16'h0000, 0);
    vecs[9]  = mk(8'h60, 16'h0040, 16'h7FFF, 0, 0, 0, 6, 1, 5'b01001, 5'b01000, 16'h7FFF, 0);
    vecs[10] = mk(8'h60, 16'h0080, 16'h0001, 6, 0, 0, 7, 1, 5'b01000, 5'b01010, 16'h8000, 0);
    vecs[11] = mk(8'h09, 16'h0100, 16'h0000, 4, 3, 1, 8, 1, 5'b01010, 5'b01000, 16'h0007, 0);
    vecs[12] = mk(8'h09, 16'h0200, 16'h0000, 3, 4, 1, 9, 1, 5'b01000, 5'b01001, 16'hFFF9, 0);
    vecs[13] = mk(8'h09, 16'h0400, 16'h0001, 7, 0, 0, 10, 1, 5'b01001, 5'b01010, 16'h7FFF, 0);
    vecs[14] = mk(8'h0B, 16'h0000, 16'h0001, 7, 0, 0, 7, 1, 5'b00110, 5'b00110, 16'h8000, 0);
    vecs[15] = mk(8'hAA, 16'hFFFF, 16'h0005, 7, 0, 0, 7, 1, 5'b00110, 5'b00110, 16'h8000, 1);
    vecs[16] = mk(8'h00, 16'hFFFF, 16'h0005, 7, 0, 0, 0, 1, 5'b00110, 5'b00110, 16'h0000, 1);
    vecs[17] = mk(8'h06, 16'h0000, 16'h0000, 7, 7, 1, 7, 1, 5'b00110, 5'b00111, 16'h8000, 1);

    // Reset held while the control inputs toggle randomly.
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      opcode = 8'($urandom); wEnable = 16'($urandom); Imm_in = 16'($urandom);
      Rdest_sel = 4'($urandom); Rsrc_sel = 4'($urandom); Imm_sel = 1'($urandom);
      dbg_sel = 4'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; opcode = OP_NOP; wEnable = 16'h0;
    clearModel();
    checkResetState("reset_random");

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end
    for (int k = 0; k < 16; k++) begin
      dbg_sel = k[3:0];
      #1;
      check($sformatf("final_regs R%0d", k), dbg_data, mdl_regs[k]);
    end

    // Reset asserted alongside a broadcast write: the write must be dropped and illegal_op cleared.
    @(negedge clk);
    reset = 1'b1; opcode = OP_ADDUI; wEnable = 16'hFFFF; Imm_in = 16'h1234;
    Rdest_sel = 4'd0; Imm_sel = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clearModel();
    checkResetState("reset_write");

    // Fibonacci run: R1=R2=1, then R5=R1+R2, R1=R2, R2=R5, with out_data mirroring R5.
    fv = mk(OP_ADDUI, 16'h0006, 16'h0001, 0, 0, 0, 2, 0, 5'b0, 5'b0, 16'h0, 0);
    applyStimulus(fv, "fib_init");
    checkOutput(fv, "fib_init");
    for (int it = 0; it < 9; it++) begin
      fv = mk(OP_ADDU, 16'h0020, 16'h0000, 1, 2, 1, 5, 0, 5'b0, 5'b0, 16'h0, 0);
      applyStimulus(fv, $sformatf("fib%0d_add", it));
      checkOutput(fv, $sformatf("fib%0d_add", it));
      fv = mk(OP_ADDUI, 16'h0002, 16'h0000, 2, 0, 0, 1, 0, 5'b0, 5'b0, 16'h0, 0);
      applyStimulus(fv, $sformatf("fib%0d_mv1", it));
      checkOutput(fv, $sformatf("fib%0d_mv1", it));
      fv = mk(OP_ADDUI, 16'h0004, 16'h0000, 5, 0, 0, 2, 0, 5'b0, 5'b0, 16'h0, 0);
      applyStimulus(fv, $sformatf("fib%0d_mv2", it));
      checkOutput(fv, $sformatf("fib%0d_mv2", it));
    end
    check("fib_out_data", out_data, 32'd89);
    dbg_sel = 4'd5;
    #1;
    check("fib_R5", dbg_data, 32'd89);
    check("fib_illegal_op", illegal_op, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
